if_fetch: RTL
=============

// Module: if_fetch
// PURPOSE
//  Instruction-fetch stage. Owns the PC, drives the instruction-memory request port and
//  feeds IR/ir_valid to the decode stage. Honours decode's stall (wait_ID) and EX's branch
//  redirect (jp_taken/jp_target). Guarantees one outstanding request, in-order delivery
//  and no lost or duplicated instruction across stalls.
// PARAMETERS
//  PC_W      32  PC / instruction-address width
//  INSTR_W   32  instruction width (matches `PC_mem_Bus)
//  RESET_PC  0   first fetch address after reset
//  PC_STEP   1   address increment per instruction
// PORTS
//  clk          in   1        single clock, all state on rising edge
//  rst          in   1        asynchronous, active-high reset
//  wait_ID      in   1        decode stall: IR/ir_valid/ir_pc must hold this cycle
//  jp_taken     in   1        one-cycle redirect pulse from EX
//  jp_target    in   PC_W     redirect address, valid with jp_taken
//  imem_req     out  1        fetch request, registered
//  imem_addr    out  PC_W     fetch address, stable while imem_req=1 until imem_valid
//  imem_valid   in   1        response strobe; ignored unless imem_req=1
//  imem_data    in   INSTR_W  instruction, valid with imem_valid
//  IR           out  INSTR_W  instruction to decode
//  ir_valid     out  1        IR holds a real instruction (0 = bubble)
//  ir_pc        out  PC_W     address of instruction in IR
//  stall_cnt    out  16       (IF_PERF_CNT_EN only) cycles with wait_ID=1
//  flush_cnt    out  16       (IF_PERF_CNT_EN only) accepted redirects
// BEHAVIOUR
//  Reset: state=REQ, imem_req=1, imem_addr=RESET_PC, IR=`NOP (all zero), ir_valid=0,
//   ir_pc=0, pend_v=0, counters=0. Reset mid-request abandons it; memory must tolerate.
//  Priority each cycle: rst > jp_taken > wait_ID > imem_valid.
//  Accept = imem_req & imem_valid. On accept, imem_addr <= imem_addr+PC_STEP (wraps mod
//   2^PC_W). Zero-wait memory yields one instruction per cycle.
//  REQ: accept & !wait_ID -> IR<=imem_data, ir_pc<=imem_addr, ir_valid<=1, stay REQ.
//   accept & wait_ID -> pend<=data/addr, pend_v<=1, imem_req<=0, go STALL.
//   No accept -> IR/ir_valid unchanged if wait_ID; otherwise ir_valid<=0 (bubble).
//  STALL (imem_req=0): wait_ID=1 holds everything. wait_ID=0 -> IR<=pend, ir_valid<=1,
//   pend_v<=0, imem_req<=1, go REQ.
//  Redirect (jp_taken=1, any state): IR<=`NOP, ir_valid<=0, pend_v<=0, flush_cnt++.
//   Takes priority over wait_ID; the current IR is squashed even when decode is stalled.
//   REQ with accept, or STALL -> imem_addr<=jp_target, imem_req<=1, go REQ; data dropped.
//   REQ without accept -> tgt<=jp_target, go DRAIN (addr held, req held).
//  DRAIN: keep imem_req=1 with the old address until imem_valid. Discard data, then
//   imem_addr<=tgt and go REQ. A second jp_taken in DRAIN overwrites tgt (last wins).
//   IR stays bubble throughout.
//  Latency: request issue to IR visible = memory latency + 1 clk.
// CONFIGURATION
//  `IF_PERF_CNT_EN defined: stall_cnt/flush_cnt ports exist; both are saturating 16-bit
//   counters. Undefined: ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  def.v gets IF state encodings (IF_REQ, IF_STALL, IF_DRAIN), `NOP, and the PC/IR bus
//   widths. Counters are a sub-module if_perf_cnt, instantiated only under the macro.
//   FSM, pend buffer and PC logic are inline.
// TESTING
//  1. Zero-wait memory, imem_data=addr: after reset, IR=0,1,2,3 on consecutive clocks,
//     ir_valid=1 from cycle 2.
//  2. wait_ID high 3 cycles mid-stream while IR=5: IR holds 5, addr 6 is buffered, and
//     imem_req=0. After release, IR=6 then 7; nothing is skipped or repeated.
//  3. jp_taken with target 0x40 while IR=9: next IR is bubble (ir_valid=0), then
//     IR=0x40 with ir_pc=0x40.
//  4. Memory with 3-cycle latency, jp_taken 1 cycle after request to 0x10: imem_addr
//     stays 0x10 until valid, data is dropped, then the 0x80 target is fetched.
//  5. jp_taken and wait_ID together: redirect wins and pend is cleared.
//     rst asserted during DRAIN: outputs take reset values asynchronously.
//  6. With IF_PERF_CNT_EN: 4 stall cycles and 2 redirects read stall_cnt=4, flush_cnt=2.
//     Without it, elaboration succeeds with no counter ports.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// ============================================================================
//  Module      : if_fetch_pkg
//  Description : Shared IF-stage constants: FSM encodings, NOP word, bus widths.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_fetch_pkg;

    localparam int PC_BUS_W   = 32;
    localparam int IR_BUS_W   = 32;
    localparam int PERF_CNT_W = 16;

    localparam logic [1:0] IF_REQ   = 2'd0;
    localparam logic [1:0] IF_STALL = 2'd1;
    localparam logic [1:0] IF_DRAIN = 2'd2;

    localparam logic [IR_BUS_W-1:0] IF_NOP = '0;

endpackage

`default_nettype wire

// File: rtl/if_perf_cnt.sv
// ============================================================================
//  Module      : if_perf_cnt
//  Description : Saturating stall / flush event counters for the fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_perf_cnt
    import if_fetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_stall,
    input  logic                  i_flush,
    output logic [PERF_CNT_W-1:0] o_stall_cnt,
    output logic [PERF_CNT_W-1:0] o_flush_cnt
);

    logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Counters stick at all-ones rather than wrapping to zero
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (i_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + PERF_CNT_W'(1);
        end
        if (i_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + PERF_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;

endmodule

`default_nettype wire

// File: rtl/if_fetch.sv
// ============================================================================
//  Module      : if_fetch
//  Description : Instruction-fetch stage: PC, single-outstanding imem request,
//                stall buffer and branch redirect. Optional perf counters are
//                built when IF_PERF_CNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int               PC_W     = PC_BUS_W,
    parameter int               INSTR_W  = IR_BUS_W,
    parameter logic [PC_W-1:0]  RESET_PC = '0,
    parameter int               PC_STEP  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wait_ID,
    input  logic                  jp_taken,
    input  logic [PC_W-1:0]       jp_target,
    output logic                  imem_req,
    output logic [PC_W-1:0]       imem_addr,
    input  logic                  imem_valid,
    input  logic [INSTR_W-1:0]    imem_data,
    output logic [INSTR_W-1:0]    IR,
    output logic                  ir_valid,
    output logic [PC_W-1:0]       ir_pc
`ifdef IF_PERF_CNT_EN
   ,output logic [PERF_CNT_W-1:0] stall_cnt,
    output logic [PERF_CNT_W-1:0] flush_cnt
`endif
);

    logic [1:0]         state_q,     state_d;
    logic               imem_req_q,  imem_req_d;
    logic [PC_W-1:0]    imem_addr_q, imem_addr_d;
    logic [INSTR_W-1:0] ir_q,        ir_d;
    logic               ir_valid_q,  ir_valid_d;
    logic [PC_W-1:0]    ir_pc_q,     ir_pc_d;
    logic [INSTR_W-1:0] pend_data_q, pend_data_d;
    logic [PC_W-1:0]    pend_addr_q, pend_addr_d;
    logic               pend_v_q,    pend_v_d;
    logic [PC_W-1:0]    tgt_q,       tgt_d;
    logic               w_accept;

    assign w_accept = imem_req_q & imem_valid;

    always_comb begin
        state_d     = state_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        ir_d        = ir_q;
        ir_valid_d  = ir_valid_q;
        ir_pc_d     = ir_pc_q;
        pend_data_d = pend_data_q;
        pend_addr_d = pend_addr_q;
        pend_v_d    = pend_v_q;
        tgt_d       = tgt_q;

        if (jp_taken) begin
            ir_d       = INSTR_W'(IF_NOP);
            ir_valid_d = 1'b0;
            pend_v_d   = 1'b0;
            // With no request in flight we can retarget now; otherwise the
            // outstanding access must complete before the address may move.
            if ((state_q == IF_STALL) || w_accept) begin
                imem_addr_d = jp_target;
                imem_req_d  = 1'b1;
                state_d     = IF_REQ;
            end else begin
                tgt_d   = jp_target;
                state_d = IF_DRAIN;
            end
        end else begin
            case (state_q)
                IF_REQ: begin
                    if (w_accept) begin
                        imem_addr_d = imem_addr_q + PC_W'(PC_STEP);
                        if (wait_ID) begin
                            pend_data_d = imem_data;
                            pend_addr_d = imem_addr_q;
                            pend_v_d    = 1'b1;
                            imem_req_d  = 1'b0;
                            state_d     = IF_STALL;
                        end else begin
                            ir_d       = imem_data;
                            ir_pc_d    = imem_addr_q;
                            ir_valid_d = 1'b1;
                        end
                    end else if (!wait_ID) begin
                        ir_valid_d = 1'b0;
                    end
                end
                IF_STALL: begin
                    if (!wait_ID && pend_v_q) begin
                        ir_d       = pend_data_q;
                        ir_pc_d    = pend_addr_q;
                        ir_valid_d = 1'b1;
                        pend_v_d   = 1'b0;
                        imem_req_d = 1'b1;
                        state_d    = IF_REQ;
                    end
                end
                IF_DRAIN: begin
                    if (w_accept) begin
                        imem_addr_d = tgt_q;
                        state_d     = IF_REQ;
                    end
                end
                default: begin
                    state_d = IF_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IF_REQ;
            imem_req_q  <= 1'b1;
            imem_addr_q <= RESET_PC;
            ir_q        <= INSTR_W'(IF_NOP);
            ir_valid_q  <= 1'b0;
            ir_pc_q     <= '0;
            pend_data_q <= '0;
            pend_addr_q <= '0;
            pend_v_q    <= 1'b0;
            tgt_q       <= '0;
        end else begin
            state_q     <= state_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            ir_q        <= ir_d;
            ir_valid_q  <= ir_valid_d;
            ir_pc_q     <= ir_pc_d;
            pend_data_q <= pend_data_d;
            pend_addr_q <= pend_addr_d;
            pend_v_q    <= pend_v_d;
            tgt_q       <= tgt_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign IR        = ir_q;
    assign ir_valid  = ir_valid_q;
    assign ir_pc     = ir_pc_q;

`ifdef IF_PERF_CNT_EN
    if_perf_cnt u_perf_cnt (
        .clk         (clk),
        .rst         (rst),
        .i_stall     (wait_ID),
        .i_flush     (jp_taken),
        .o_stall_cnt (stall_cnt),
        .o_flush_cnt (flush_cnt)
    );
`endif

endmodule

`default_nettype wire
